mmio_arbiter: RTL and testbench
===============================

MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 SHALL have parameter BASE_HI, default 16'hFFFF, the required value of addr[31:16] for a valid MMIO access.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports m0_req / m1_req  input  1  access request from master 0 (CPU data port) / master 1 (DMA/debug).
REQ-005 SHALL have ports m0_we / m1_we  input  1  write request (1) or read request (0).
REQ-006 SHALL have ports m0_be / m1_be  input  4  byte enables.
REQ-007 SHALL have ports m0_addr / m1_addr  input  32  physical address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  32  write data.
REQ-009 SHALL have ports m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports m0_err / m1_err  output  1  one-cycle error pulse, coincident with ack.
REQ-011 SHALL have ports m0_rdata / m1_rdata  output  32  registered read data, valid while ack is high.
REQ-012 SHALL have ports s_we  output  1,  s_be  output  4,  s_addr  output  32,  s_wdata  output  32  shared MMIO slave bus.
REQ-013 SHALL have port s_rdata  input  32  combinational slave read data.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, DONE; IDLE->ACCESS when any req is high; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-016 SHALL, on the IDLE->ACCESS edge, latch the winner's we, be, addr and wdata into internal registers, together with the winner's index.
REQ-017 SHALL arbitrate round-robin: single requester wins; if both request, the master not granted last wins; last-granted index updates only on the IDLE->ACCESS edge.
REQ-018 SHALL drive s_addr, s_be and s_wdata from the latched registers at all times.
REQ-019 SHALL assert s_we only in ACCESS, and only when latched we=1 and the latched addr[31:16]==BASE_HI.
REQ-020 SHALL drive s_be=4'b0000 outside ACCESS and for an invalid address.
REQ-021 SHALL capture on the ACCESS->DONE edge: rdata = s_rdata for a valid read, 32'h0 for a write or an invalid address.
REQ-022 SHALL, in DONE, assert ack (and err if addr[31:16]!=BASE_HI) for the granted master only; the other master's ack and err SHALL stay 0.
REQ-023 SHALL hold each mN_rdata until that master's next completion.
REQ-024 SHALL keep the latency from the req-sampled edge to ack high at exactly 2 cycles; one transaction is 3 cycles, with back-to-back throughput of 1 per 3 cycles.
REQ-025 SHALL treat as the master's obligation: hold req and request fields stable until ack, then drop req at the edge ending the ack cycle; a req still high in IDLE SHALL start a new transaction.
REQ-026 SHALL ignore changes to master inputs during ACCESS/DONE, because the latched copy is used.
REQ-027 SHALL NOT register req while not in IDLE; a master's request is serviced when IDLE next samples it high.

Reset
REQ-028 SHALL, on rst low, asynchronously force: state=IDLE; last-granted=1 (master 0 wins the first tie); latched we=0, be=0, addr=0, wdata=0; s_we=0; all ack/err=0; m0_rdata=m1_rdata=0; busy=0.
REQ-029 SHALL abandon an in-flight transaction on reset with no ack, and with no s_we after rst asserts.
REQ-030 SHALL leave the FSM in IDLE on rst deassertion, sampling req from the first following edge.

Verification
REQ-031 SHALL cover: m0 write addr 32'hFFFF0010, be=4'hF, wdata=32'h12345678 -> s_we high exactly 1 cycle with s_addr 32'hFFFF0010; m0_ack 2 cycles after the req edge; m0_err=0; m0_rdata=0.
REQ-032 SHALL cover: m1 read addr 32'hFFFF0014 with s_rdata=32'h0000A5A5 -> s_we=0 throughout; m1_ack with m1_rdata=32'h0000A5A5; m0_ack stays 0.
REQ-033 SHALL cover: m0 and m1 request in the same cycle after reset, both holding req -> grant order m0, m1, m0, m1; acks 3 cycles apart.
REQ-034 SHALL cover: m0 write to 32'h00001000 -> no s_we, s_be=0; m0_ack and m0_err together; m0_rdata=0.
REQ-035 SHALL cover: m1 changes addr and wdata during ACCESS -> s_addr/s_wdata keep the latched values; the transaction completes with the original values.
REQ-036 SHALL cover: rst pulsed low during ACCESS of a write -> s_we drops immediately; no ack; busy=0; a subsequent m1 request completes normally.

Source files
------------

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter in front of a single MMIO slave bus.
// Each access runs IDLE -> ACCESS -> DONE, using a copy of the request latched at the grant.
module mmio_arbiter #(
    parameter logic [15:0] BASE_HI = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, last_q, we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] m0_rdata_q, m1_rdata_q, rdata_d;
    logic        win, grant, valid;

    // On a tie the master not served last wins; a lone requester always wins.
    assign win   = (m0_req && m1_req) ? ~last_q : m1_req;
    assign grant = (state_q == IDLE) && (m0_req || m1_req);
    assign valid = (addr_q[31:16] == BASE_HI);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (m0_req || m1_req) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rdata_d = (valid && !we_q) ? s_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            m0_rdata_q <= 32'h0;
            m1_rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_q   <= win;
                last_q  <= win;
                we_q    <= win ? m1_we    : m0_we;
                be_q    <= win ? m1_be    : m0_be;
                addr_q  <= win ? m1_addr  : m0_addr;
                wdata_q <= win ? m1_wdata : m0_wdata;
            end
            if (state_q == ACCESS) begin
                if (gnt_q) m1_rdata_q <= rdata_d;
                else       m0_rdata_q <= rdata_d;
            end
        end
    end

    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_we     = (state_q == ACCESS) && we_q && valid;
    assign s_be     = ((state_q == ACCESS) && valid) ? be_q : 4'h0;
    assign busy     = (state_q != IDLE);
    assign m0_ack   = (state_q == DONE) && !gnt_q;
    assign m1_ack   = (state_q == DONE) &&  gnt_q;
    assign m0_err   = m0_ack && !valid;
    assign m1_err   = m1_ack && !valid;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench for mmio_arbiter: drivers queue per-master expectations from the
// address map and slave data model; a negedge monitor checks every completion.
module tb_mmio_arbiter;
    localparam logic [15:0] BASE = 16'hFFFF;

    logic        clk = 1'b0, rst = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_we, busy;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    mmio_arbiter #(.BASE_HI(BASE)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t q0[$], q1[$];
    int   gnt_log[$], ack_cyc[$];
    int   checks = 0, errors = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: read data is a fixed function of the address.
    function automatic logic [31:0] slave_f(input logic [31:0] a);
        return (a == 32'hFFFF0014) ? 32'h0000A5A5 : {a[15:0] ^ 16'h3C3C, ~a[15:0]};
    endfunction
    assign s_rdata = slave_f(s_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Bus activity between completions belongs to the transaction that completes next.
    int          swe_cnt = 0, be_cnt = 0;
    logic [31:0] snap_addr = 0, snap_wdata = 0;
    logic [3:0]  snap_be = 0, be_seen = 0;
    logic [31:0] hold0 = 0, hold1 = 0;

    task automatic check_resp(input string who, input exp_t e, input logic err, input logic [31:0] rd);
        logic ok;
        logic vw;
        ok = (e.addr[31:16] == BASE);
        vw = e.we && ok;
        chk({who, "_err"}, {31'h0, err}, {31'h0, e.err});
        chk({who, "_rdata"}, rd, e.rdata);
        chk({who, "_swe_cycles"}, swe_cnt, vw ? 1 : 0);
        chk({who, "_be_cycles"}, be_cnt, (ok && e.be != 0) ? 1 : 0);
        chk({who, "_be"}, {28'h0, be_seen}, {28'h0, ok ? e.be : 4'h0});
        if (vw) begin
            chk({who, "_s_addr"}, snap_addr, e.addr);
            chk({who, "_s_wdata"}, snap_wdata, e.wdata);
            chk({who, "_s_be_wr"}, {28'h0, snap_be}, {28'h0, e.be});
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            swe_cnt = 0; be_cnt = 0; be_seen = 0; hold0 = 0; hold1 = 0;
            chk("rst_rdata0", m0_rdata, 32'h0);
            chk("rst_rdata1", m1_rdata, 32'h0);
        end else begin
            if (s_we) begin
                swe_cnt++; snap_addr = s_addr; snap_wdata = s_wdata; snap_be = s_be;
            end
            if (s_be != 0) begin be_cnt++; be_seen = s_be; end
            if (!busy) begin
                chk("idle_s_we", {31'h0, s_we}, 32'h0);
                chk("idle_s_be", {28'h0, s_be}, 32'h0);
            end
            if (m0_ack && m1_ack) chk("dual_ack", 32'h1, 32'h0);
            if (m0_ack) begin
                if (q0.size() == 0) chk("m0_spurious_ack", 32'h1, 32'h0);
                else begin
                    e = q0.pop_front();
                    check_resp("m0", e, m0_err, m0_rdata);
                    hold0 = e.rdata;
                end
                gnt_log.push_back(0); ack_cyc.push_back(cyc);
            end else chk("m0_rdata_hold", m0_rdata, hold0);
            if (m1_ack) begin
                if (q1.size() == 0) chk("m1_spurious_ack", 32'h1, 32'h0);
                else begin
                    e = q1.pop_front();
                    check_resp("m1", e, m1_err, m1_rdata);
                    hold1 = e.rdata;
                end
                gnt_log.push_back(1); ack_cyc.push_back(cyc);
            end else chk("m1_rdata_hold", m1_rdata, hold1);
            if (m0_ack || m1_ack) begin
                swe_cnt = 0; be_cnt = 0; be_seen = 0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with req dropped after the ack cycle.
    task automatic issue(input int m, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit scramble, output int lat);
        exp_t e;
        int   t0, n;
        bit   scr_done;
        logic ack;
        e.we = we; e.be = be; e.addr = addr; e.wdata = wd;
        e.err   = (addr[31:16] != BASE);
        e.rdata = (!we && !e.err) ? slave_f(addr) : 32'h0;
        if (m == 0) begin
            q0.push_back(e);
            m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            q1.push_back(e);
            m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd; m1_req = 1'b1;
        end
        t0 = cyc; n = 0; scr_done = 0; lat = -1;
        forever begin
            @(negedge clk);
            ack = (m == 0) ? m0_ack : m1_ack;
            if (ack) begin lat = cyc - t0; break; end
            if (scramble && busy && !scr_done) begin
                scr_done = 1;
                if (m == 0) begin m0_addr = ~addr; m0_wdata = ~wd; end
                else        begin m1_addr = ~addr; m1_wdata = ~wd; end
            end
            if (++n > 60) begin
                chk($sformatf("m%0d_ack_timeout", m), 32'h0, 32'h1);
                break;
            end
        end
        @(posedge clk); #1;
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic rand_master(input int m, input int n);
        logic [31:0] r;
        logic [31:0] a;
        int lat;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            a = ($urandom_range(0, 1) == 1) ? {BASE, r[15:0]} : r;
            issue(m, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, 0, lat);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_s_we", {31'h0, s_we}, 32'h0);
        chk("rst_s_be", {28'h0, s_be}, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wdata", s_wdata, 32'h0);
        chk("rst_acks", {30'h0, m0_ack, m1_ack}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        issue(0, 1'b1, 4'hF, 32'hFFFF0010, 32'h12345678, 0, lat);
        chk("wr_latency", lat, 2);
        issue(1, 1'b0, 4'hF, 32'hFFFF0014, 32'h0, 0, lat);
        chk("rd_latency", lat, 2);
        chk("rd_m1_rdata_a5", m1_rdata, 32'h0000A5A5);
        issue(0, 1'b1, 4'hF, 32'h00001000, 32'hCAFEF00D, 0, lat);
        issue(1, 1'b1, 4'h3, 32'hFFFF0020, 32'hDEADBEEF, 1, lat);
        issue(1, 1'b0, 4'hC, 32'hFFFF0020, 32'h0, 0, lat);

        // Simultaneous held requests right after reset.
        do_reset();
        gnt_log.delete(); ack_cyc.delete();
        fork
            begin issue(0, 1'b0, 4'hF, 32'hFFFF0100, 32'h0, 0, lat);
                  issue(0, 1'b1, 4'h1, 32'hFFFF0104, 32'h11, 0, lat); end
            begin issue(1, 1'b0, 4'hF, 32'hFFFF0200, 32'h0, 0, lat);
                  issue(1, 1'b1, 4'h2, 32'hFFFF0204, 32'h22, 0, lat); end
        join
        chk("tie_count", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), gnt_log[i], i % 2);
            for (int i = 1; i < 4; i++) chk($sformatf("tie_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
        end

        // Reset in the middle of a valid write.
        m0_we = 1; m0_be = 4'hF; m0_addr = 32'hFFFF0040; m0_wdata = 32'hA1B2C3D4; m0_req = 1;
        @(posedge clk); #1;
        chk("pre_rst_s_we", {31'h0, s_we}, 32'h1);
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_s_we", {31'h0, s_we}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_ack", {30'h0, m0_ack, m1_ack}, 32'h0);
        chk("mid_rst_s_be", {28'h0, s_be}, 32'h0);
        m0_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        issue(1, 1'b0, 4'hF, 32'hFFFF0014, 32'h0, 0, lat);
        chk("post_rst_latency", lat, 2);

        fork
            rand_master(0, 40);
            rand_master(1, 40);
        join
        repeat (5) @(posedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
